// File: rtl/calc_alu.sv
// Sequential 4-bit calculator ALU: add/sub in one cycle, shift-add multiply and
// restoring divide over ITER cycles, with a synchronised active-low button start.
module calc_alu #(
    parameter int unsigned ITER = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    input  logic [3:0] arif,
    output logic [7:0] result,
    output logic [1:0] control,
    output logic       busy,
    output logic       done
);

    localparam int unsigned OPW   = 4;
    localparam int unsigned RESW  = 8;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    logic [OPW-1:0]   s1, s2, s3;
    logic [0:0]       state, state_nxt;
    logic [1:0]       op, op_nxt, op_sel;
    logic [RESW-1:0]  a_reg, a_nxt;
    logic [OPW-1:0]   b_reg, b_nxt;
    logic [RESW-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RESW-1:0]  result_nxt;
    logic [1:0]       control_nxt;
    logic             busy_nxt, done_nxt;

    logic             start;
    logic             last_iter;
    logic [OPW-1:0]   sub_mag;
    logic             sub_neg;
    logic [RESW-1:0]  mul_acc;
    logic [OPW:0]     rem_sh;
    logic             div_fit;
    logic [RESW-1:0]  div_acc;

    // Button synchroniser plus previous-sample register for press detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 4'hF;
            s2 <= 4'hF;
            s3 <= 4'hF;
        end else begin
            s1 <= arif;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start = (s3 == 4'hF) && (s2 != 4'hF);

    // Lowest-index pressed button wins
    always_comb begin
        op_sel = OP_DIV;
        if (!s2[0])      op_sel = OP_ADD;
        else if (!s2[1]) op_sel = OP_SUB;
        else if (!s2[2]) op_sel = OP_MUL;
    end

    assign last_iter = (cnt == CNT_W'(ITER - 1));

    always_comb begin
        sub_neg = (a_reg[OPW-1:0] < b_reg);
        sub_mag = sub_neg ? (b_reg - a_reg[OPW-1:0]) : (a_reg[OPW-1:0] - b_reg);
    end

    assign mul_acc = acc + (b_reg[0] ? a_reg : RESW'(0));

    // Restoring divide: acc = {remainder, dividend/quotient}, shifted left each step
    always_comb begin
        rem_sh  = {acc[7:4], acc[3]};
        div_fit = (rem_sh >= {1'b0, b_reg});
        if (div_fit) begin
            div_acc = {OPW'(rem_sh - {1'b0, b_reg}), acc[2:0], 1'b1};
        end else begin
            div_acc = {rem_sh[OPW-1:0], acc[2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op      <= OP_ADD;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            control <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            op      <= op_nxt;
            a_reg   <= a_nxt;
            b_reg   <= b_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            result  <= result_nxt;
            control <= control_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        op_nxt      = op;
        a_nxt       = a_reg;
        b_nxt       = b_reg;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        result_nxt  = result;
        control_nxt = control;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    op_nxt    = op_sel;
                    a_nxt     = RESW'(op_a);
                    b_nxt     = op_b;
                    acc_nxt   = (op_sel == OP_DIV) ? RESW'(op_a) : RESW'(0);
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op)
                    OP_ADD: begin
                        result_nxt  = RESW'(a_reg[OPW-1:0]) + RESW'(b_reg);
                        control_nxt = 2'b00;
                        done_nxt    = 1'b1;
                    end
                    OP_SUB: begin
                        result_nxt  = RESW'(sub_mag);
                        control_nxt = {1'b0, sub_neg};
                        done_nxt    = 1'b1;
                    end
                    OP_MUL: begin
                        acc_nxt = mul_acc;
                        a_nxt   = a_reg << 1;
                        b_nxt   = b_reg >> 1;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (last_iter) begin
                            result_nxt  = mul_acc;
                            control_nxt = 2'b00;
                            done_nxt    = 1'b1;
                        end
                    end
                    default: begin
                        if (b_reg == '0) begin
                            result_nxt  = 8'hFF;
                            control_nxt = 2'b10;
                            done_nxt    = 1'b1;
                        end else begin
                            acc_nxt = div_acc;
                            cnt_nxt = cnt + CNT_W'(1);
                            if (last_iter) begin
                                result_nxt  = div_acc;
                                control_nxt = 2'b00;
                                done_nxt    = 1'b1;
                            end
                        end
                    end
                endcase
                if (done_nxt) begin
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_calc_alu.sv
// Self-checking bench for calc_alu: directed cases, reset abort and random ops
// compared against an arithmetic reference model.
module tb_calc_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] op_a, op_b, arif;
    logic [7:0] result;
    logic [1:0] control;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_res = 8'h00;
    logic [1:0] exp_ctl = 2'b00;

    calc_alu #(.ITER(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_a    (op_a),
        .op_b    (op_b),
        .arif    (arif),
        .result  (result),
        .control (control),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the pressed operation
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] pat,
                         output logic [7:0] r, output logic [1:0] c, output int lat);
        int ia, ib;
        ia  = int'(a);
        ib  = int'(b);
        c   = 2'b00;
        lat = 1;
        if (!pat[0]) begin
            r = 8'(ia + ib);
        end else if (!pat[1]) begin
            if (ia >= ib) r = 8'(ia - ib);
            else begin
                r = 8'(ib - ia);
                c = 2'b01;
            end
        end else if (!pat[2]) begin
            r   = 8'(ia * ib);
            lat = 4;
        end else if (ib == 0) begin
            r = 8'hFF;
            c = 2'b10;
        end else begin
            r   = 8'(((ia % ib) * 16) + (ia / ib));
            lat = 4;
        end
    endtask

    // Press pat for hold cycles; optionally inject a second press at cycle inj_k
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] pat,
                          input int hold, input int inj_k, input logic [3:0] inj_pat);
        logic [7:0] r;
        logic [1:0] c;
        int lat, fin, total, ndone;
        model(a, b, pat, r, c, lat);
        op_a  = a;
        op_b  = b;
        arif  = pat;
        ndone = 0;
        fin   = 3 + lat;
        total = ((hold > fin) ? hold : fin) + 6;
        for (int k = 1; k <= total; k++) begin
            step();
            if (k == 3) begin
                op_a = ~a;
                op_b = ~b;
            end
            check("busy", 8'(busy), 8'((k >= 3 && k < fin) ? 1 : 0));
            if (k < fin) begin
                check("done_early", 8'(done), 8'h00);
                check("result_hold", result, exp_res);
                check("control_hold", 8'(control), 8'(exp_ctl));
            end else if (k == fin) begin
                check("done_pulse", 8'(done), 8'h01);
                check("result", result, r);
                check("control", 8'(control), 8'(c));
            end else begin
                check("done_late", 8'(done), 8'h00);
                check("result_after", result, r);
            end
            if (done) ndone++;
            if (k == hold) arif = 4'hF;
            if (k == inj_k) arif = inj_pat;
            if (k == inj_k + 1) arif = 4'hF;
        end
        check("done_count", 8'(ndone), 8'h01);
        exp_res = r;
        exp_ctl = c;
    endtask

    initial begin
        rst_n = 1'b0;
        arif  = 4'hF;
        op_a  = 4'h0;
        op_b  = 4'h0;
        step();
        step();
        check("rst_result", result, 8'h00);
        check("rst_control", 8'(control), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_done", 8'(done), 8'h00);
        rst_n = 1'b1;
        step();

        run_op(4'd15, 4'd15, 4'b1110, 2, -10, 4'hF);   // add
        run_op(4'd3,  4'd9,  4'b1101, 2, -10, 4'hF);   // sub negative
        run_op(4'd9,  4'd3,  4'b1101, 2, -10, 4'hF);   // sub positive
        run_op(4'd15, 4'd15, 4'b1011, 2, -10, 4'hF);   // mul
        run_op(4'd13, 4'd4,  4'b0111, 2, -10, 4'hF);   // div
        run_op(4'd7,  4'd0,  4'b0111, 2, -10, 4'hF);   // div by zero
        run_op(4'd5,  4'd6,  4'b1100, 2, -10, 4'hF);   // priority -> add
        run_op(4'd11, 4'd13, 4'b1011, 1, 4, 4'b1110);  // second press during mul
        run_op(4'd2,  4'd3,  4'b1101, 100, -10, 4'hF); // held button

        // Reset in the middle of a multiply aborts it
        op_a = 4'd14;
        op_b = 4'd9;
        arif = 4'b1011;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) arif = 4'hF;
        end
        check("mid_busy", 8'(busy), 8'h01);
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 8'h00);
        check("abort_control", 8'(control), 8'h00);
        check("abort_busy", 8'(busy), 8'h00);
        check("abort_done", 8'(done), 8'h00);
        step();
        rst_n = 1'b1;
        exp_res = 8'h00;
        exp_ctl = 2'b00;
        for (int k = 0; k < 6; k++) begin
            step();
            check("abort_no_done", 8'(done), 8'h00);
            check("abort_hold", result, 8'h00);
        end
        run_op(4'd6, 4'd7, 4'b1011, 3, -10, 4'hF);     // normal after reset

        for (int i = 0; i < 25; i++) begin
            run_op(4'($urandom), 4'($urandom), 4'($urandom_range(0, 14)),
                   int'($urandom_range(1, 8)), -10, 4'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_alu.md
# calc_alu

Sequential arithmetic unit for the 4-bit calculator. It sits between the operand registers loaded from the switches and the seven-segment display driver. It takes the two latched operands and the active-low operation buttons, and computes add, subtract, multiply or divide. Multiply and divide use iterative shift-add and restoring-division datapaths. The 8-bit result and status flags are presented to the display stage.

## Interface
Parameters:
- `ITER`, default 4: iteration count for multiply and divide. Equals the operand width and is fixed at 4.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `op_a`, input, 4: operand A, unsigned. Sampled only at start.
- `op_b`, input, 4: operand B, unsigned. Sampled only at start.
- `arif`, input, 4: operation buttons, active-low, asynchronous. Bit 0 = add, bit 1 = sub, bit 2 = mul, bit 3 = div.
- `result`, output, 8: last completed result, registered.
- `control`, output, 2: bit 0 = negative, bit 1 = error (divide by zero). Registered, updated together with `result`.
- `busy`, output, 1: high while an operation is executing.
- `done`, output, 1: one-cycle pulse when `result` and `control` update.

## Operation
- **Input synchroniser:** `arif` passes through 2 flops (s1, s2). A third register (s3) holds the previous s2.
- **Start event:** s3 == 4'hF and s2 != 4'hF, meaning a press from the all-released state. s3 updates every cycle in every state, so a press made while busy is consumed and never starts anything.
- **Priority:** if several bits are low in the start cycle, the lowest index wins (add > sub > mul > div).
- **States:** IDLE, EXEC.
  - IDLE + start: latch `op_a`, `op_b` and the op code, clear the iteration counter, set `busy`, go to EXEC.
  - IDLE, no start: stay.
  - EXEC: add, sub and divide-by-zero finish after 1 cycle. Mul and div run `ITER` cycles. On the final cycle, register `result`/`control`, pulse `done`, clear `busy`, return to IDLE.
- **Add:** `result` = zero-extended A + B (max 30). `control` = 2'b00.
- **Sub:**
  - A >= B: `result` = A − B, negative = 0.
  - A < B: `result` = B − A, negative = 1.
  - error = 0.
- **Mul:** shift-add, one multiplier bit per cycle, LSB first. 8-bit accumulator. `result` = A·B (max 225). `control` = 2'b00.
- **Div:** restoring division, one quotient bit per cycle, MSB first.
  - `result[3:0]` = quotient, `result[7:4]` = remainder. `control` = 2'b00.
  - B == 0: no iteration. `result` = 8'hFF, `control` = 2'b10, finishes in 1 EXEC cycle.
- **Holding outputs:** `result` and `control` hold between operations. Intermediate accumulator values never appear on `result`.
- **Reset (asynchronous):**
  - s1, s2, s3 = 4'hF.
  - state = IDLE, `busy` = 0, `done` = 0.
  - `result` = 8'h00, `control` = 2'b00.
  - Internal operand and accumulator registers = 0.
  - Reset mid-operation aborts it. No `done` is produced for the aborted op.

## Timing
- Button falling at the pin before edge P: s1 at P, s2 at P+1, capture at edge P+2.
- Let capture edge = C.
  - Add, sub, div-by-zero: `result`/`control` valid and `done` = 1 after edge C+1, for one cycle.
  - Mul, div: the same happens after edge C+ITER (C+4).
- `busy` is high from after C until after the final EXEC edge. It is never high in the same cycle that `done` is high.
- Back-to-back: a new start may be captured the cycle after `done`. This requires a release (s3 == 4'hF) in between.
- Operand changes while busy have no effect.
- Holding a button produces exactly one operation.

## Test plan
- A=15, B=15, press add → `result` = 8'h1E, `control` = 00, `done` 1 cycle after capture, `busy` high for exactly 1 cycle.
- A=3, B=9, press sub → `result` = 8'h06, `control` = 01. Then A=9, B=3 → 8'h06, `control` = 00.
- A=15, B=15, press mul → `busy` high 4 cycles, `result` = 8'hE1. Prior result is held unchanged during `busy`.
- A=13, B=4, press div → `result` = 8'h13 (q=3, r=1).
- A=7, B=0, press div → 8'hFF, `control` = 10, `done` after 1 cycle.
- Each of the following is checked:
  - `arif` = 4'b1100 → add.
  - A second press during mul → ignored; exactly one `done`.
  - Holding a button 100 cycles → one `done`.
  - `rst_n` pulsed low mid-mul → `result` = 0, `busy` = 0, no `done`.
  - The next press after reset works normally.
